// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between the CPU load/store path and an
// external burst master. The CPU owns the port by default. A pending external
// request takes the port when the CPU is idle, or once the CPU has won
// MAX_CPU_RUN consecutive cycles while the request waited. After acceptance,
// an external burst runs to completion, one beat per cycle, and stalls the CPU.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata      CPU access request (byte address, 16-bit data)
//   cpu_rdata, cpu_stall       load data (pass-through), access-not-done flag
//   ext_valid/we/addr/len      burst request (len = beats minus one)
//   ext_wdata                  write data for the current beat
//   ext_ready, ext_beat        accept pulse, beat-performed flag
//   ext_rvalid, ext_rdata      registered read data, one cycle after a read beat
//   mem_addr/wdata/we/re       memory port, mem_rdata combinational read data
module dmem_arbiter #(
   parameter int MAX_CPU_RUN = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        ext_valid,
   input  logic        ext_we,
   input  logic [15:0] ext_addr,
   input  logic [3:0]  ext_len,
   input  logic [15:0] ext_wdata,
   output logic        ext_ready,
   output logic        ext_beat,
   output logic        ext_rvalid,
   output logic [15:0] ext_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [15:0] mem_rdata
);

   localparam logic [3:0] MAX_RUN = 4'(MAX_CPU_RUN);

   typedef enum logic {IDLE, EXT} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  beat_cnt_reg, beat_cnt_next;
   logic [15:0] addr_reg, addr_next;
   logic [3:0]  starve_cnt_reg, starve_cnt_next;
   logic        ext_rvalid_reg;
   logic [15:0] ext_rdata_reg;
   logic        accept;
   logic        cpu_grant;
   logic        read_beat;

   // Acceptance is suppressed while reset is held so that no beat leaks out
   // before a fresh request is seen after release.
   assign accept = !reset && (state_reg == IDLE) && ext_valid &&
                   (!cpu_req || (starve_cnt_reg == MAX_RUN));

   always_comb begin
      state_next      = state_reg;
      beat_cnt_next   = beat_cnt_reg;
      addr_next       = addr_reg;
      starve_cnt_next = starve_cnt_reg;
      ext_ready       = 1'b0;
      ext_beat        = 1'b0;
      cpu_stall       = 1'b0;
      cpu_grant       = 1'b0;
      mem_addr        = 16'h0000;
      mem_wdata       = 16'h0000;
      mem_we          = 1'b0;
      mem_re          = 1'b0;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               // First beat goes out in the accept cycle itself.
               ext_ready = 1'b1;
               ext_beat  = 1'b1;
               cpu_stall = cpu_req;
               mem_addr  = ext_addr;
               mem_wdata = ext_wdata;
               mem_we    = ext_we;
               mem_re    = ~ext_we;
               if (ext_len != 4'd0) begin
                  state_next    = EXT;
                  beat_cnt_next = ext_len;
                  addr_next     = ext_addr + 16'd2;
               end
            end else if (cpu_req) begin
               cpu_grant = 1'b1;
               mem_addr  = cpu_addr;
               mem_wdata = cpu_wdata;
               mem_we    = cpu_we;
               mem_re    = ~cpu_we;
            end
         end
         EXT: begin
            // beat_cnt counts beats still owed after the accept beat.
            ext_beat      = 1'b1;
            cpu_stall     = cpu_req;
            mem_addr      = addr_reg;
            mem_wdata     = ext_wdata;
            mem_we        = ext_we;
            mem_re        = ~ext_we;
            addr_next     = addr_reg + 16'd2;
            beat_cnt_next = beat_cnt_reg - 4'd1;
            if (beat_cnt_reg == 4'd1) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // Counts CPU wins against a waiting request; saturates at the limit.
      if (!ext_valid || accept) begin
         starve_cnt_next = 4'd0;
      end else if (cpu_grant && (starve_cnt_reg != MAX_RUN)) begin
         starve_cnt_next = starve_cnt_reg + 4'd1;
      end
   end

   assign read_beat = ext_beat & ~ext_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         beat_cnt_reg   <= 4'd0;
         addr_reg       <= 16'h0000;
         starve_cnt_reg <= 4'd0;
         ext_rvalid_reg <= 1'b0;
         ext_rdata_reg  <= 16'h0000;
      end else begin
         state_reg      <= state_next;
         beat_cnt_reg   <= beat_cnt_next;
         addr_reg       <= addr_next;
         starve_cnt_reg <= starve_cnt_next;
         ext_rvalid_reg <= read_beat;
         if (read_beat) begin
            ext_rdata_reg <= mem_rdata;
         end
      end
   end

   assign ext_rvalid = ext_rvalid_reg;
   assign ext_rdata  = ext_rdata_reg;
   assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Randomized and directed stimulus against a cycle-level reference model
// (remaining-beat count, wait-run count, word-array memory image).
module tb_dmem_arbiter;

   localparam int MAX_RUN = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        ext_valid, ext_we;
   logic [15:0] ext_addr, ext_wdata;
   logic [3:0]  ext_len;
   logic        ext_ready, ext_beat, ext_rvalid;
   logic [15:0] ext_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;

   dmem_arbiter #(.MAX_CPU_RUN(MAX_RUN)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
      .ext_wdata(ext_wdata), .ext_ready(ext_ready), .ext_beat(ext_beat),
      .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Physical memory seen by the DUT.
   bit [15:0] tb_mem [0:32767];
   assign mem_rdata = tb_mem[mem_addr[15:1]];
   always @(posedge clk) if (mem_we) tb_mem[mem_addr[15:1]] <= mem_wdata;

   // Reference model state.
   bit [15:0]   ref_mem [0:32767];
   int          m_left;
   logic [15:0] m_addr;
   int          m_run;
   bit          m_pv;
   logic [15:0] m_pd, m_last;
   bit          obs_ready, exp_stall;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_left = 0; m_run = 0; m_pv = 0; m_last = 16'h0000; m_addr = 16'h0000;
      exp_stall = 0; obs_ready = 0;
   endtask

   function automatic logic [15:0] pick_addr();
      if ($urandom % 2 == 0) return 16'h0100 + 16'(2 * $urandom_range(0, 15));
      else                   return 16'hFFF0 + 16'(2 * $urandom_range(0, 7));
   endfunction

   // Entered just after a falling edge with inputs already applied; returns
   // at the next falling edge.
   task automatic cycle();
      bit          in_burst, take, beat, cpu_go, bwe;
      logic [15:0] baddr;
      #1;
      in_burst = (m_left > 0);
      take = 0; beat = 0; cpu_go = 0; bwe = 0; baddr = 16'h0000;
      if (in_burst) begin
         beat = 1; baddr = m_addr; bwe = ext_we;
      end else if (ext_valid && (!cpu_req || m_run == MAX_RUN)) begin
         take = 1; beat = 1; baddr = ext_addr; bwe = ext_we;
      end else if (cpu_req) begin
         cpu_go = 1;
      end
      check("ext_ready", 16'(ext_ready), 16'(take));
      check("ext_beat", 16'(ext_beat), 16'(beat));
      check("cpu_stall", 16'(cpu_stall), 16'(beat && cpu_req));
      if (beat) begin
         check("ext_mem_addr", mem_addr, baddr);
         check("ext_mem_we", 16'(mem_we), 16'(bwe));
         check("ext_mem_re", 16'(mem_re), 16'(!bwe));
         if (bwe) check("ext_mem_wdata", mem_wdata, ext_wdata);
      end else if (cpu_go) begin
         check("cpu_mem_addr", mem_addr, cpu_addr);
         check("cpu_mem_we", 16'(mem_we), 16'(cpu_we));
         check("cpu_mem_re", 16'(mem_re), 16'(!cpu_we));
         if (cpu_we) check("cpu_mem_wdata", mem_wdata, cpu_wdata);
         else        check("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[15:1]]);
      end else begin
         check("idle_mem_we", 16'(mem_we), 16'h0);
         check("idle_mem_re", 16'(mem_re), 16'h0);
         check("idle_mem_addr", mem_addr, 16'h0000);
      end
      obs_ready = ext_ready;
      exp_stall = beat && cpu_req;
      // Advance the model.
      m_pv = beat && !bwe;
      if (m_pv) m_pd = ref_mem[baddr[15:1]];
      if (beat && bwe) ref_mem[baddr[15:1]] = ext_wdata;
      if (cpu_go && cpu_we) ref_mem[cpu_addr[15:1]] = cpu_wdata;
      if (!ext_valid || take) m_run = 0;
      else if (cpu_go && m_run < MAX_RUN) m_run++;
      if (take) begin
         m_left = int'(ext_len); m_addr = ext_addr + 16'd2;
      end else if (in_burst) begin
         m_left--; m_addr = m_addr + 16'd2;
      end
      @(posedge clk);
      #1;
      check("ext_rvalid", 16'(ext_rvalid), 16'(m_pv));
      if (m_pv) m_last = m_pd;
      check("ext_rdata", ext_rdata, m_last);
      @(negedge clk);
   endtask

   task automatic set_cpu(input bit req, input bit we, input logic [15:0] a, input logic [15:0] d);
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_ext(input bit v, input bit we, input logic [15:0] a, input logic [3:0] len);
      ext_valid = v; ext_we = we; ext_addr = a; ext_len = len; ext_wdata = 16'($urandom);
   endtask

   initial begin
      int ready_at;
      reset = 1'b1;
      set_cpu(1, 0, 16'h0100, 16'h0000);
      set_ext(0, 0, 16'h0000, 4'd0);
      model_reset();
      #1;
      check("rst_rvalid", 16'(ext_rvalid), 16'h0);
      check("rst_rdata", ext_rdata, 16'h0000);
      check("rst_beat", 16'(ext_beat), 16'h0);
      check("rst_stall", 16'(cpu_stall), 16'h0);
      @(posedge clk); @(negedge clk);
      reset = 1'b0;

      // Starvation limit: CPU wins MAX_RUN cycles, then ext is accepted.
      set_cpu(1, 0, 16'h0200, 16'h0000);
      set_ext(1, 0, 16'h0300, 4'd0);
      ready_at = -1;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (obs_ready) begin ready_at = k; break; end
      end
      check("starve_ready_cycle", 16'(ready_at), 16'(MAX_RUN));
      set_ext(0, 0, 16'h0000, 4'd0);

      // Single-beat write, then CPU reads it back next cycle.
      set_cpu(0, 0, 16'h0000, 16'h0000);
      set_ext(1, 1, 16'h0300, 4'd0);
      cycle();
      check("len0_ready", 16'(obs_ready), 16'h1);
      set_ext(0, 0, 16'h0000, 4'd0);
      set_cpu(1, 0, 16'h0300, 16'h0000);
      cycle();

      // Write burst across the top of the address space, CPU readback.
      set_cpu(0, 0, 16'h0000, 16'h0000);
      set_ext(1, 1, 16'hFFFC, 4'd2);
      cycle();
      ext_valid = 0; ext_wdata = 16'($urandom); cycle();
      ext_wdata = 16'($urandom); cycle();
      set_cpu(1, 0, 16'hFFFC, 16'h0000); cycle();
      set_cpu(1, 0, 16'hFFFE, 16'h0000); cycle();
      set_cpu(1, 0, 16'h0000, 16'h0000); cycle();

      // Fill 0x0100..0x0106, read it back as a burst while the CPU waits.
      set_cpu(0, 0, 16'h0000, 16'h0000);
      set_ext(1, 1, 16'h0100, 4'd3);
      for (int k = 0; k < 4; k++) begin cycle(); ext_valid = 0; ext_wdata = 16'($urandom); end
      set_ext(1, 0, 16'h0100, 4'd3);
      cycle();
      ext_valid = 0;
      set_cpu(1, 0, 16'h0102, 16'h0000);
      for (int k = 0; k < 3; k++) cycle();
      cycle();
      set_cpu(0, 0, 16'h0000, 16'h0000);
      cycle();

      // Reset during the second beat of a six-beat read burst.
      set_ext(1, 0, 16'h0110, 4'd5);
      cycle();
      ext_valid = 0;
      set_cpu(1, 0, 16'h0104, 16'h0000);
      #1;
      check("beat2_before_rst", 16'(ext_beat), 16'h1);
      reset = 1'b1;
      #1;
      check("rst_mid_beat", 16'(ext_beat), 16'h0);
      check("rst_mid_stall", 16'(cpu_stall), 16'h0);
      check("rst_mid_rvalid", 16'(ext_rvalid), 16'h0);
      check("rst_mid_rdata", ext_rdata, 16'h0000);
      model_reset();
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      cycle();
      cycle();

      // Randomized traffic.
      set_cpu(0, 0, 16'h0000, 16'h0000);
      for (int i = 0; i < 3000; i++) begin
         if (!exp_stall) begin
            cpu_req   = ($urandom % 3) != 0;
            cpu_we    = 1'($urandom % 2);
            cpu_addr  = pick_addr();
            cpu_wdata = 16'($urandom);
         end
         if (m_left > 0) begin
            ext_wdata = 16'($urandom);
            ext_valid = 1'($urandom % 2);
            ext_addr  = pick_addr();
         end else if (ext_valid && !obs_ready) begin
            ext_wdata = ext_wdata;
         end else begin
            ext_valid = ($urandom % 3) == 0;
            ext_we    = 1'($urandom % 2);
            ext_addr  = pick_addr();
            ext_len   = 4'($urandom_range(0, 5));
            ext_wdata = 16'($urandom);
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_CPU_RUN, default 8, consecutive CPU-won cycles allowed while ext is waiting (range 1..15).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cpu_req  in  1  CPU data access this cycle (mem_read | mem_write).
REQ-005 cpu_we  in  1  CPU write enable. cpu_addr  in  16  byte address. cpu_wdata  in  16  store data.
REQ-006 cpu_rdata  out  16  load data, combinational pass of mem_rdata.
REQ-007 cpu_stall  out  1  CPU access not performed this cycle; CPU holds PC and request.
REQ-008 ext_valid  in  1  ext burst request pending. ext_we  in  1  burst direction. ext_addr  in  16  start address. ext_len  in  4  beats minus one.
REQ-009 ext_wdata  in  16  write data for the current beat.
REQ-010 ext_ready  out  1  request accepted (one-cycle pulse).
REQ-011 ext_beat  out  1  ext beat performed this cycle.
REQ-012 ext_rvalid  out  1, ext_rdata  out  16  registered read data, one cycle after each read beat.
REQ-013 mem_addr  out  16, mem_wdata  out  16, mem_we  out  1, mem_re  out  1 to data memory; mem_rdata  in  16  combinational read data.

Function
REQ-014 FSM states: IDLE (CPU owns port), EXT (burst in progress); reset state IDLE.
REQ-015 In IDLE, ext accepted when ext_valid=1 and (cpu_req=0 or starve_cnt==MAX_CPU_RUN); otherwise CPU granted.
REQ-016 Accept cycle: ext_ready=1, ext_beat=1, first beat at ext_addr using ext_we/ext_wdata; cpu_stall=cpu_req.
REQ-017 Accept with ext_len=0: remain IDLE; ext_len>0: go to EXT, load beat_cnt=ext_len, addr_reg=ext_addr+2.
REQ-018 Each EXT cycle: one beat at addr_reg, ext_beat=1, ext_we/ext_wdata taken from live inputs; addr_reg+=2 mod 2^16 (0xFFFE wraps to 0x0000); beat_cnt-=1.
REQ-019 EXT exits to IDLE in the cycle after the beat performed with beat_cnt==1; total beats = ext_len+1, one per cycle, no gaps.
REQ-020 In EXT, cpu_stall=cpu_req; ext_valid and ext_addr ignored until back in IDLE; ext_ready=0.
REQ-021 CPU grant: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we, mem_re=~cpu_we, cpu_stall=0.
REQ-022 Ext beat: mem_we=ext_we, mem_re=~ext_we; no grant (IDLE, cpu_req=0, ext not accepted): mem_we=0, mem_re=0, mem_addr=0.
REQ-023 starve_cnt (4 bit): +1 on each cycle CPU granted while ext_valid=1; cleared on ext accept or when ext_valid=0; saturates at MAX_CPU_RUN.
REQ-024 ext_rvalid=1 and ext_rdata=mem_rdata registered on the clock after every read beat; ext_rvalid=0 otherwise, ext_rdata holds.
REQ-025 cpu_rdata=mem_rdata always; valid only when cpu_stall=0 and cpu_we=0.
REQ-026 Simultaneous cpu_req and ext_valid with starve_cnt<MAX_CPU_RUN: CPU wins, no ext_ready.

Reset
REQ-027 Reset asserted: state=IDLE, beat_cnt=0, addr_reg=0, starve_cnt=0, ext_rvalid=0, ext_rdata=0 immediately, independent of clk.
REQ-028 Reset mid-burst aborts remaining beats; no ext_ready, ext_beat or ext_rvalid until a new accept after reset release.
REQ-029 During reset, combinational outputs follow IDLE rules (cpu_stall=0; memory driven by CPU inputs).

Verification
REQ-030 cpu_req=1 continuous, ext_valid=1 at cycle 0, MAX_CPU_RUN=8 -> CPU granted cycles 0-7, ext_ready at cycle 8, cpu_stall=1 at cycle 8.
REQ-031 ext_valid, ext_we=0, ext_addr=0x0100, ext_len=3, cpu_req=0 -> beats at 0x0100,0x0102,0x0104,0x0106 in 4 consecutive cycles; 4 ext_rvalid pulses each one cycle later with the stored words.
REQ-032 ext write burst ext_addr=0xFFFC, ext_len=2 -> mem_we at 0xFFFC,0xFFFE,0x0000; readback by CPU matches.
REQ-033 reset asserted on 2nd beat of ext_len=5 burst -> state IDLE immediately, ext_beat=0, ext_rvalid=0; next CPU load after release performed with cpu_stall=0.
REQ-034 cpu_req=1 during 4-beat EXT burst -> cpu_stall=1 for all 4 beats, CPU load completes on the following cycle with correct data.
REQ-035 ext_len=0, cpu_req=0 -> single ext_ready/ext_beat pulse, state stays IDLE, next cycle CPU granted.
